// File: rtl/unary_to_binary_decoder_if.sv
// unary_to_binary_decoder_if: unary bit stream in, decoded result out under valid/ready
interface unary_to_binary_decoder_if #(parameter int WIDTH = 4);
    logic             start;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic [WIDTH:0]   count_out;
    logic [WIDTH-1:0] bin_out;
    logic             therm_err;
    logic             out_valid;
    logic             out_ready;
    modport master(output start, bit_in, bit_valid, out_ready,
                   input busy, count_out, bin_out, therm_err, out_valid);
    modport slave(input start, bit_in, bit_valid, out_ready,
                  output busy, count_out, bin_out, therm_err, out_valid);
endinterface

// File: rtl/unary_to_binary_decoder.sv
// unary_to_binary_decoder: counts ones over a 2^WIDTH-bit frame, decodes value, flags non-thermometer frames
module unary_to_binary_decoder #(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst,
    unary_to_binary_decoder_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [WIDTH-1:0] LAST = '1;
    logic [1:0]       state;
    logic [WIDTH:0]   ones, ones_n, count_r;
    logic [WIDTH-1:0] idx, bin_r;
    logic             seen_zero, err, err_n, err_r, take, last, restart;
    always_comb begin
        take    = state == ACCUM && bus.bit_valid;
        last    = take && idx == LAST;
        ones_n  = ones + (WIDTH+1)'(bus.bit_in);
        err_n   = err | (bus.bit_in & seen_zero);
        restart = bus.start && (state == IDLE || (state == DONE && bus.out_ready));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ones      <= '0;
            idx       <= '0;
            seen_zero <= 1'b0;
            err       <= 1'b0;
            count_r   <= '0;
            bin_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            if (restart) begin
                ones      <= '0;
                idx       <= '0;
                seen_zero <= 1'b0;
                err       <= 1'b0;
            end else if (take) begin
                ones      <= ones_n;
                idx       <= idx + WIDTH'(1);
                seen_zero <= seen_zero | ~bus.bit_in;
                err       <= err_n;
            end
            // Result registers change only on the final bit so they hold through IDLE/ACCUM
            if (last) begin
                count_r <= ones_n;
                bin_r   <= ones_n == '0 ? '0 : WIDTH'(ones_n - (WIDTH+1)'(1));
                err_r   <= err_n;
            end
            state <= restart ? ACCUM :
                     last ? DONE :
                     (state == DONE && bus.out_ready) ? IDLE : state;
        end
    end
    assign bus.busy      = state == ACCUM;
    assign bus.out_valid = state == DONE;
    assign bus.count_out = count_r;
    assign bus.bin_out   = bin_r;
    assign bus.therm_err = err_r;
endmodule
